// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stall/flush sequencer and the pipeline-register modules.
// Holds the sequencer states, the event classes and the bundled register controls.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NORMAL   = 2'd0,
    EV_MEM_BUSY = 2'd1,
    EV_BRANCH   = 2'd2,
    EV_LOAD_USE = 2'd3
  } event_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
    logic mem_wb_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_NORMAL = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0
  };

  // Everything frozen except WB, which retires once and then sees bubbles.
  localparam pipe_ctl_t CTL_MEM_BUSY = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b1, mem_wb_bubble: 1'b1
  };

  localparam pipe_ctl_t CTL_BRANCH = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0
  };

  localparam pipe_ctl_t CTL_LOAD_USE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1, mem_wb_bubble: 1'b0
  };

  localparam pipe_ctl_t CTL_HALT = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_bubble: 1'b0
  };

  localparam pipe_ctl_t CTL_RESET = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1, id_ex_en: 1'b0,
    id_ex_flush: 1'b1, ex_mem_en: 1'b0, mem_wb_en: 1'b0, mem_wb_bubble: 1'b1
  };

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
// Loads to $0 never create a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  output logic       load_use
);

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits, taken branches
// and load-use hazards, with a wait watchdog and saturating performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_RegisterRs,
  input  logic [4:0]    id_RegisterRt,
  input  logic [4:0]    ex_RegisterRt,
  input  logic          ex_MemRead,
  input  logic          ex_branch_taken,
  input  logic          dmem_req,
  input  logic          dmem_ready,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          if_id_flush,
  output logic          id_ex_en,
  output logic          id_ex_flush,
  output logic          ex_mem_en,
  output logic          mem_wb_en,
  output logic          mem_wb_bubble,
  output logic          mem_err,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          load_use;
  logic          mem_busy;
  event_t        ev;
  pipe_ctl_t     ctl;

  hazard_detect u_hazard_detect (
    .id_rs       (id_RegisterRs),
    .id_rt       (id_RegisterRt),
    .ex_rt       (ex_RegisterRt),
    .ex_mem_read (ex_MemRead),
    .load_use    (load_use)
  );

  assign mem_busy = dmem_req & ~dmem_ready;

  // A pending branch is held during a memory wait; a taken branch squashes the ID
  // instruction, so its load-use hazard is irrelevant.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    ev = EV_NORMAL;
    if (state != ERR) begin
      if (mem_busy)             ev = EV_MEM_BUSY;
      else if (ex_branch_taken) ev = EV_BRANCH;
      else if (load_use)        ev = EV_LOAD_USE;
    end
  end

  always_comb begin
    ctl = CTL_NORMAL;
    if (!rst) begin
      ctl = CTL_RESET;
    end else if (state == ERR) begin
      ctl = CTL_HALT;
    end else begin
      case (ev)
        EV_MEM_BUSY: ctl = CTL_MEM_BUSY;
        EV_BRANCH:   ctl = CTL_BRANCH;
        EV_LOAD_USE: ctl = CTL_LOAD_USE;
        default:     ctl = CTL_NORMAL;
      endcase
    end
  end

  assign pc_en         = ctl.pc_en;
  assign if_id_en      = ctl.if_id_en;
  assign if_id_flush   = ctl.if_id_flush;
  assign id_ex_en      = ctl.id_ex_en;
  assign id_ex_flush   = ctl.id_ex_flush;
  assign ex_mem_en     = ctl.ex_mem_en;
  assign mem_wb_en     = ctl.mem_wb_en;
  assign mem_wb_bubble = ctl.mem_wb_bubble;
  assign mem_err       = (state == ERR);

  // wait_cnt counts busy cycles already spent; the busy cycle that finds it at
  // MAX_WAIT is the (MAX_WAIT+1)-th and trips the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            state    <= MEM_WAIT;
            wait_cnt <= WW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_busy) begin
            if (wait_cnt == WW'(MAX_WAIT)) state <= ERR;
            else                           wait_cnt <= wait_cnt + WW'(1);
          end else begin
            state    <= RUN;
            wait_cnt <= '0;
          end
        end
        ERR:     state <= ERR;
        default: state <= ERR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if ((ev == EV_MEM_BUSY || ev == EV_LOAD_USE) && stall_count != '1)
        stall_count <= stall_count + CW'(1);
      if (ev == EV_BRANCH && flush_count != '1)
        flush_count <= flush_count + CW'(1);
    end
  end

endmodule
